// File: rtl/arilla_bus_pkg.sv
// Shared types and helpers for the arilla bus arbiter: FSM state encoding,
// round-robin index stepping and wait-counter sizing.
package arilla_bus_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Next candidate index in round-robin order, wrapping at n.
    function automatic int unsigned rr_next_index(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    // Wait counter is at least 8 bits and wide enough to hold the timeout value.
    function automatic int unsigned wait_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/arilla_bus_rr_picker.sv
// Round-robin priority picker: scans the request vector starting one past the
// last served index and returns a one-hot winner plus a valid flag.
module rr_picker
    import arilla_bus_pkg::*;
#(
    parameter int NumMasters = 2,
    localparam int IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
    input  logic [NumMasters-1:0] req,
    input  logic [IdxW-1:0]       last,
    output logic [NumMasters-1:0] grant,
    output logic                  valid
);

    logic [IdxW-1:0] cand;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = last;
        for (int k = 0; k < NumMasters; k++) begin
            cand = IdxW'(rr_next_index(32'(cand), NumMasters));
            if (!valid && req[cand]) begin
                grant[cand] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter sharing one system bus between NumMasters requesters,
// with a bounded wait for bus_available and a one-cycle arbitration slot.
module arilla_bus_arbiter
    import arilla_bus_pkg::*;
#(
    parameter int NumMasters       = 2,
    parameter int DataWidth        = 32,
    parameter int ByteAddressWidth = 32,
    parameter int ByteSize         = 8,
    parameter int TimeoutCycles    = 255,
    localparam int ByteEnableWidth = DataWidth / ByteSize
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NumMasters*ByteAddressWidth-1:0] m_address,
    input  logic [NumMasters-1:0]                 m_read,
    input  logic [NumMasters-1:0]                 m_write,
    input  logic [NumMasters*DataWidth-1:0]       m_data_out,
    input  logic [NumMasters*ByteEnableWidth-1:0] m_byteenable,
    output logic [NumMasters-1:0]                 m_grant,
    output logic [NumMasters-1:0]                 m_done,
    output logic [NumMasters-1:0]                 m_error,
    output logic [DataWidth-1:0]                  m_data_in,
    output logic [ByteAddressWidth-1:0]           bus_address,
    output logic                                  bus_read,
    output logic                                  bus_write,
    output logic [DataWidth-1:0]                  bus_data_out,
    output logic [ByteEnableWidth-1:0]            bus_byteenable,
    input  logic [DataWidth-1:0]                  bus_data_in,
    input  logic                                  bus_available,
    output arb_state_t                            dbg_state
);

    // Handshake: a master holds m_read/m_write (and its address/data) until it
    // sees m_done or m_error; bus_available high with a bus strobe high means
    // the slave accepts and completes the transfer in that same cycle.

    localparam int IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int CntW = wait_cnt_width(TimeoutCycles);
    localparam logic [IdxW-1:0] LastReset = IdxW'(NumMasters - 1);
    localparam logic [CntW-1:0] CntLimit  = CntW'(TimeoutCycles);

    arb_state_t             state;
    logic [IdxW-1:0]        last_served;
    logic [IdxW-1:0]        grant_idx;
    logic [CntW-1:0]        wait_cnt;

    logic [NumMasters-1:0]  req_vec;
    logic [NumMasters-1:0]  pick_grant;
    logic                   pick_valid;
    logic [IdxW-1:0]        pick_idx;

    logic                   owned;
    logic                   g_read;
    logic                   g_write;
    logic                   g_active;
    logic                   complete;
    logic                   timed_out;
    logic                   release_bus;

    assign req_vec = m_read | m_write;

    rr_picker #(
        .NumMasters(NumMasters)
    ) u_picker (
        .req  (req_vec),
        .last (last_served),
        .grant(pick_grant),
        .valid(pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NumMasters; i++) begin
            if (pick_grant[i]) pick_idx = IdxW'(i);
        end
    end

    assign owned    = (state == OWNED);
    assign g_read   = owned & (|(m_read & m_grant));
    assign g_write  = owned & (|(m_write & m_grant));
    assign g_active = g_read | g_write;

    // Completion takes priority over a timeout landing in the same cycle.
    assign complete    = g_active & bus_available;
    assign timed_out   = g_active & ~bus_available & (wait_cnt == CntLimit);
    assign release_bus = owned & (~g_active | complete | timed_out);

    always_comb begin
        bus_address    = '0;
        bus_data_out   = '0;
        bus_byteenable = '0;
        for (int i = 0; i < NumMasters; i++) begin
            if (owned && m_grant[i]) begin
                bus_address    = m_address[i*ByteAddressWidth +: ByteAddressWidth];
                bus_data_out   = m_data_out[i*DataWidth +: DataWidth];
                bus_byteenable = m_byteenable[i*ByteEnableWidth +: ByteEnableWidth];
            end
        end
    end

    // Simultaneous read and write from one master is resolved as a read.
    assign bus_read  = g_read & ~timed_out;
    assign bus_write = g_write & ~g_read & ~timed_out;

    assign m_done    = complete ? m_grant : '0;
    assign m_error   = timed_out ? m_grant : '0;
    assign m_data_in = complete ? bus_data_in : '0;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_grant     <= '0;
            grant_idx   <= '0;
            last_served <= LastReset;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= OWNED;
                        m_grant   <= pick_grant;
                        grant_idx <= pick_idx;
                        wait_cnt  <= '0;
                    end
                end
                OWNED: begin
                    if (release_bus) begin
                        state       <= IDLE;
                        m_grant     <= '0;
                        last_served <= grant_idx;
                    end else if (!bus_available) begin
                        wait_cnt <= wait_cnt + CntW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Self-checking bench for arilla_bus_arbiter: directed scenarios plus a
// randomized run compared against a transaction-level reference model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif
`ifndef BLEN
`define BLEN 8
`endif

module tb_arilla_bus_arbiter;
    import arilla_bus_pkg::*;

    localparam int N   = 3;
    localparam int DW  = `XLEN;
    localparam int AW  = `ALEN;
    localparam int BS  = `BLEN;
    localparam int BEW = DW / BS;
    localparam int TO  = 8;

    logic             clk;
    logic             rst_n;
    logic [N*AW-1:0]  m_address;
    logic [N-1:0]     m_read;
    logic [N-1:0]     m_write;
    logic [N*DW-1:0]  m_data_out;
    logic [N*BEW-1:0] m_byteenable;
    logic [N-1:0]     m_grant;
    logic [N-1:0]     m_done;
    logic [N-1:0]     m_error;
    logic [DW-1:0]    m_data_in;
    logic [AW-1:0]    bus_address;
    logic             bus_read;
    logic             bus_write;
    logic [DW-1:0]    bus_data_out;
    logic [BEW-1:0]   bus_byteenable;
    logic [DW-1:0]    bus_data_in;
    logic             bus_available;
    arb_state_t       dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q[$];

    arilla_bus_arbiter #(
        .NumMasters      (N),
        .DataWidth       (`XLEN),
        .ByteAddressWidth(`ALEN),
        .ByteSize        (`BLEN),
        .TimeoutCycles   (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_data_out    (m_data_out),
        .m_byteenable  (m_byteenable),
        .m_grant       (m_grant),
        .m_done        (m_done),
        .m_error       (m_error),
        .m_data_in     (m_data_in),
        .bus_address   (bus_address),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_data_out  (bus_data_out),
        .bus_byteenable(bus_byteenable),
        .bus_data_in   (bus_data_in),
        .bus_available (bus_available),
        .dbg_state     (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change at the falling edge, outputs sampled 1 ns later.
    task automatic clear_inputs();
        m_address     = '0;
        m_read        = '0;
        m_write       = '0;
        m_data_out    = '0;
        m_byteenable  = '0;
        bus_data_in   = '0;
        bus_available = 1'b0;
    endtask

    task automatic drive_master(input int i, input logic rd, input logic wr,
                                input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic [BEW-1:0] be);
        m_read[i]                 = rd;
        m_write[i]                = wr;
        m_address[i*AW +: AW]     = addr;
        m_data_out[i*DW +: DW]    = data;
        m_byteenable[i*BEW +: BEW] = be;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) drive_master(i, 1'b1, 1'b0, AW'(32'h40 + i), DW'(i), '1);
        bus_available = 1'b1;
        bus_data_in   = DW'(32'h12345678);
        for (int r = 0; r < 2; r++) begin
            #1;
            vectors++;
            if ({m_grant, m_done, m_error, bus_read, bus_write} !== '0) begin
                miscompares++;
                $display("FAIL reset_ctrl: got %b expected 0", {m_grant, m_done, m_error, bus_read, bus_write});
            end
            vectors++;
            if ({bus_address, bus_data_out, m_data_in} !== '0 || dbg_state !== IDLE) begin
                miscompares++;
                $display("FAIL reset_data: got addr %h wdata %h rdata %h state %0d expected 0",
                         bus_address, bus_data_out, m_data_in, dbg_state);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (m_grant !== N'(1)) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b expected %b", m_grant, N'(1));
        end
        clear_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        drive_master(0, 1'b1, 1'b0, AW'(32'h100), '0, '1);
        #1;
        vectors++;
        if (m_grant !== '0 || m_done !== '0) begin
            miscompares++;
            $display("FAIL single_arb_cycle: got grant %b done %b expected 0", m_grant, m_done);
        end
        @(negedge clk);
        bus_available = 1'b1;
        bus_data_in   = DW'(32'hDEADBEEF);
        #1;
        vectors++;
        if (m_grant !== N'(1) || bus_read !== 1'b1 || bus_write !== 1'b0 || bus_address !== AW'(32'h100)) begin
            miscompares++;
            $display("FAIL single_bus: got grant %b rd %b wr %b addr %h expected 001 1 0 100",
                     m_grant, bus_read, bus_write, bus_address);
        end
        vectors++;
        if (m_done !== N'(1) || m_data_in !== DW'(32'hDEADBEEF)) begin
            miscompares++;
            $display("FAIL single_done: got done %b data %h expected 001 deadbeef", m_done, m_data_in);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        vectors++;
        if (m_grant !== '0 || m_done !== '0) begin
            miscompares++;
            $display("FAIL single_release: got grant %b done %b expected 0", m_grant, m_done);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_g;
        logic [DW-1:0] exp_d;
        do_reset();
        drive_master(0, 1'b0, 1'b1, AW'(32'h10), DW'(32'h11111111), '1);
        drive_master(1, 1'b0, 1'b1, AW'(32'h20), DW'(32'h22222222), '1);
        bus_available = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            #1;
            exp_g = '0;
            if (c % 2 == 1) exp_g = N'(1) << (((c - 1) / 2) % 2);
            vectors++;
            if (m_grant !== exp_g || m_done !== exp_g) begin
                miscompares++;
                $display("FAIL contention_c%0d: got grant %b done %b expected %b", c, m_grant, m_done, exp_g);
            end
            if (exp_g != '0) begin
                exp_d = (exp_g == N'(1)) ? DW'(32'h11111111) : DW'(32'h22222222);
                vectors++;
                if (bus_data_out !== exp_d || bus_write !== 1'b1) begin
                    miscompares++;
                    $display("FAIL contention_data_c%0d: got %h wr %b expected %h 1", c, bus_data_out, bus_write, exp_d);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        int dones;
        int done_at;
        bit drop;
        dones   = 0;
        done_at = -1;
        drop    = 1'b0;
        do_reset();
        drive_master(0, 1'b0, 1'b1, AW'(32'h200), DW'(32'hCAFEF00D), BEW'(4'hF));
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (drop) drive_master(0, 1'b0, 1'b0, '0, '0, '0);
            bus_available = ((k / 4) % 2 == 1);
            #1;
            vectors++;
            if (m_grant[0] !== (k >= 1 && k <= 4)) begin
                miscompares++;
                $display("FAIL stall_grant_k%0d: got %b expected %b", k, m_grant[0], (k >= 1 && k <= 4));
            end
            if (m_grant[0]) begin
                vectors++;
                if (bus_write !== 1'b1 || bus_address !== AW'(32'h200) ||
                    bus_data_out !== DW'(32'hCAFEF00D) || bus_byteenable !== BEW'(4'hF)) begin
                    miscompares++;
                    $display("FAIL stall_bus_k%0d: got wr %b addr %h data %h be %h expected 1 200 cafef00d f",
                             k, bus_write, bus_address, bus_data_out, bus_byteenable);
                end
            end
            if (m_done[0]) begin
                dones++;
                done_at = k;
                drop    = 1'b1;
            end
        end
        vectors++;
        if (dones !== 1 || done_at !== 4) begin
            miscompares++;
            $display("FAIL stall_done_count: got %0d at %0d expected 1 at 4", dones, done_at);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic [N-1:0] exp_err;
        logic [N-1:0] exp_g;
        do_reset();
        drive_master(1, 1'b1, 1'b0, AW'(32'h300), '0, '1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            #1;
            exp_err = (k == 9) ? N'(2) : '0;
            exp_g   = (k <= 9) ? N'(2) : '0;
            vectors++;
            if (m_grant !== exp_g || m_error !== exp_err || m_done !== '0 || bus_read !== (k <= 8)) begin
                miscompares++;
                $display("FAIL timeout_k%0d: got grant %b err %b done %b rd %b expected %b %b 000 %b",
                         k, m_grant, m_error, m_done, bus_read, exp_g, exp_err, (k <= 8));
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_master(2, 1'b0, 1'b1, AW'(32'h400), DW'(32'h55), '1);
        @(negedge clk);
        #1;
        vectors++;
        if (m_grant !== N'(4) || bus_write !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_owned: got grant %b wr %b expected 100 1", m_grant, bus_write);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_grant !== '0 || bus_write !== 1'b0 || bus_address !== '0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL rstmid_async: got grant %b wr %b addr %h state %0d expected 0",
                     m_grant, bus_write, bus_address, dbg_state);
        end
        for (int i = 0; i < N; i++) drive_master(i, 1'b1, 1'b0, AW'(32'h700 + i), '0, '1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (m_grant !== N'(1)) begin
            miscompares++;
            $display("FAIL rstmid_first: got grant %b expected %b", m_grant, N'(1));
        end
        clear_inputs();
    endtask

    task automatic test_withdraw();
        do_reset();
        drive_master(1, 1'b1, 1'b0, AW'(32'h500), '0, '1);
        @(negedge clk);
        drive_master(0, 1'b1, 1'b0, AW'(32'h600), '0, '1);
        #1;
        vectors++;
        if (m_grant !== N'(2) || m_done !== '0 || m_error !== '0) begin
            miscompares++;
            $display("FAIL withdraw_owned: got grant %b done %b err %b expected 010 0 0", m_grant, m_done, m_error);
        end
        @(negedge clk);
        drive_master(1, 1'b0, 1'b0, '0, '0, '0);
        #1;
        vectors++;
        if (m_grant !== N'(2) || m_done !== '0 || m_error !== '0 || bus_read !== 1'b0) begin
            miscompares++;
            $display("FAIL withdraw_drop: got grant %b done %b err %b rd %b expected 010 0 0 0",
                     m_grant, m_done, m_error, bus_read);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (m_grant !== '0 || m_done !== '0 || m_error !== '0) begin
            miscompares++;
            $display("FAIL withdraw_release: got grant %b done %b err %b expected 0", m_grant, m_done, m_error);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (m_grant !== N'(1) || bus_address !== AW'(32'h600)) begin
            miscompares++;
            $display("FAIL withdraw_next: got grant %b addr %h expected 001 600", m_grant, bus_address);
        end
        clear_inputs();
    endtask

    // Reference model: owner index (-1 when the bus is free), last served
    // index and cycles waited, advanced once per clock from the rules.
    task automatic test_random(input int cycles);
        int owner;
        int last;
        int waited;
        int cand;
        bit g_rd;
        bit g_wr;
        bit active;
        bit fin_ok;
        bit fin_to;
        logic [N-1:0]   exp_grant;
        logic [N-1:0]   exp_done;
        logic [N-1:0]   exp_err;
        logic           exp_rd;
        logic           exp_wr;
        logic [DW-1:0]  exp_d;
        int kind;
        owner  = -1;
        last   = N - 1;
        waited = 0;
        exp_q.delete();
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            if (c > 0) @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    kind = $urandom_range(0, 3);
                    m_read[i]  = (kind == 1 || kind == 3);
                    m_write[i] = (kind == 2 || kind == 3);
                end
                m_address[i*AW +: AW]      = AW'($urandom);
                m_data_out[i*DW +: DW]     = DW'($urandom);
                m_byteenable[i*BEW +: BEW] = BEW'($urandom);
            end
            bus_available = ((c / 60) % 2 == 1) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 1) == 1);
            bus_data_in   = DW'($urandom);
            #1;
            exp_grant = '0;
            exp_done  = '0;
            exp_err   = '0;
            exp_rd    = 1'b0;
            exp_wr    = 1'b0;
            active    = 1'b0;
            fin_ok    = 1'b0;
            fin_to    = 1'b0;
            if (owner >= 0) begin
                g_rd   = m_read[owner];
                g_wr   = m_write[owner];
                active = g_rd || g_wr;
                fin_ok = active && bus_available;
                fin_to = active && !bus_available && (waited == TO);
                exp_grant[owner] = 1'b1;
                exp_done[owner]  = fin_ok;
                exp_err[owner]   = fin_to;
                exp_rd = g_rd && !fin_to;
                exp_wr = g_wr && !g_rd && !fin_to;
                if (fin_ok) exp_q.push_back(bus_data_in);
            end
            vectors++;
            if ({m_grant, m_done, m_error, bus_read, bus_write} !== {exp_grant, exp_done, exp_err, exp_rd, exp_wr} ||
                dbg_state !== ((owner >= 0) ? OWNED : IDLE)) begin
                miscompares++;
                $display("FAIL random_ctrl_c%0d: got g%b d%b e%b r%b w%b expected g%b d%b e%b r%b w%b",
                         c, m_grant, m_done, m_error, bus_read, bus_write, exp_grant, exp_done, exp_err, exp_rd, exp_wr);
            end
            if (owner >= 0) begin
                vectors++;
                if (bus_address !== m_address[owner*AW +: AW] || bus_data_out !== m_data_out[owner*DW +: DW] ||
                    bus_byteenable !== m_byteenable[owner*BEW +: BEW]) begin
                    miscompares++;
                    $display("FAIL random_mux_c%0d: got addr %h data %h be %h expected master %0d signals",
                             c, bus_address, bus_data_out, bus_byteenable, owner);
                end
            end
            if (m_done !== '0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL random_rdata_c%0d: got unexpected done %b expected none", c, m_done);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (m_data_in !== exp_d) begin
                        miscompares++;
                        $display("FAIL random_rdata_c%0d: got %h expected %h", c, m_data_in, exp_d);
                    end
                end
            end
            if (owner >= 0) begin
                if (!active || fin_ok || fin_to) begin
                    last  = owner;
                    owner = -1;
                end else begin
                    waited++;
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    cand = (last + k) % N;
                    if (owner < 0 && (m_read[cand] || m_write[cand])) begin
                        owner  = cand;
                        waited = 0;
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_pending: got %0d unmatched completions expected 0", exp_q.size());
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_stall();
        test_timeout();
        test_reset_mid();
        test_withdraw();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arilla_bus_arbiter.md
ARILLA_BUS_ARBITER -- requirements
Module: arilla_bus_arbiter

Interface
REQ-001 SHALL have parameter NumMasters, default 2, number of bus requesters (2..4).
REQ-002 SHALL have parameters DataWidth 32, ByteAddressWidth 32, ByteSize 8, matching the system bus; ByteEnableWidth = DataWidth/ByteSize.
REQ-003 SHALL have parameter TimeoutCycles, default 255, maximum wait cycles for bus_available before abort.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 m_address  in  NumMasters*ByteAddressWidth  per-master byte address.
REQ-007 m_read, m_write  in  NumMasters each  per-master request strobes; both high at once is illegal and treated as read.
REQ-008 m_data_out  in  NumMasters*DataWidth  per-master write data.
REQ-009 m_byteenable  in  NumMasters*ByteEnableWidth  per-master byte enables.
REQ-010 m_grant, m_done, m_error  out  NumMasters each  one-hot grant; one-cycle completion pulse; one-cycle timeout pulse.
REQ-011 m_data_in  out  DataWidth  shared read-data return, valid only with m_done.
REQ-012 bus_address, bus_read, bus_write, bus_data_out, bus_byteenable  out  as above  shared bus master side.
REQ-013 bus_data_in  in  DataWidth; bus_available  in  1  slave accepts/completes this cycle.

Function
REQ-014 SHALL implement FSM states IDLE and OWNED.
REQ-015 IDLE: bus_read/bus_write low; if any master requests, register grant to winner, enter OWNED next cycle (1-cycle arbitration latency).
REQ-016 Arbitration round-robin: search starts at index after last served master, wraps modulo NumMasters; after reset last served = NumMasters-1 (master 0 first).
REQ-017 OWNED: bus outputs combinationally mux granted master's signals; other masters' requests ignored.
REQ-018 Completion: in OWNED, cycle with granted strobe high and bus_available high -> m_done[g]=1, m_data_in=bus_data_in that cycle; next state IDLE; last served = g.
REQ-019 Timeout: wait counter (8 bits min, width from TimeoutCycles) clears on OWNED entry, increments each OWNED cycle without bus_available; at count==TimeoutCycles -> m_error[g]=1, bus strobes low that cycle, next IDLE, last served = g.
REQ-020 Request withdrawn while OWNED (granted read and write both low) -> no done/error, next IDLE, last served = g.
REQ-021 Completion and timeout same cycle: completion wins, no error.
REQ-022 m_grant high for granted master throughout OWNED, zero in IDLE; m_done, m_error never high outside OWNED.
REQ-023 Minimum transaction = 2 cycles (arbitrate + complete); back-to-back requests from one master have 1 IDLE cycle between.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, all outputs 0, counter 0, last served NumMasters-1, regardless of transaction in progress.
REQ-025 First arbitration SHALL occur on first rising edge with rst_n high.

Structure
REQ-026 State enum and round-robin next-index function SHALL live in shared package arilla_bus_pkg.
REQ-027 Round-robin priority picker SHALL be sub-module rr_picker (inputs request vector, last index; output one-hot, valid); rest stays in arilla_bus_arbiter.
REQ-028 Bus widths SHALL come from the system XLEN/ALEN/BLEN defines at instantiation.

Verification
REQ-029 Single master: m0 read 0x100, bus_available high on OWNED cycle 1, bus_data_in=0xDEADBEEF -> m_done[0] cycle 2, m_data_in=0xDEADBEEF.
REQ-030 Contention: m0, m1 request writes same cycle from reset -> m0 granted first, m1 granted after one IDLE cycle; holding both requests alternates 0,1,0,1.
REQ-031 Stall: bus_available alternates 4 cycles high/4 low, write 0xCAFEF00D byteenable 0xF -> bus outputs stable until accept, exactly one m_done.
REQ-032 Timeout: TimeoutCycles=8, bus_available held low -> m_error[g] pulse on 9th OWNED cycle, no m_done, back to IDLE.
REQ-033 Reset mid-transaction: rst_n low during OWNED -> outputs 0 same cycle asynchronously; after release master 0 served first.
REQ-034 Withdrawal: m1 drops m_read while OWNED -> grant released next cycle, no done/error, m0 pending request granted next.
